ppu_pixel_out: RTL and testbench

PPU_PIXEL_OUT -- requirements
Module: ppu_pixel_out

---
 rtl/ppu_pkg.sv | 44 ++++
 rtl/nes_rgb_lut.sv | 22 ++
 rtl/ppu_pixel_out.sv | 164 ++++++++++++++++
 tb/tb_ppu_pixel_out.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU pixel-output definitions: frame geometry defaults, palette window,
// pipeline stage records and the fixed NES master palette.
package ppu_pkg;

    localparam int DEF_VIS_LINES = 240;
    localparam int DEF_VIS_DOTS  = 256;

    localparam logic [13:0] PALETTE_BASE = 14'h3F00;

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic        grey;
        logic [4:0]  index;
    } dot_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic        grey;
        logic [5:0]  color;
    } pix_t;

    localparam logic [23:0] RGB_TABLE [0:63] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Sprite-side backdrop slots 0x10/14/18/1C alias the background ones.
    function automatic logic [4:0] pal_mirror(input logic [4:0] a);
        pal_mirror = (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    function automatic logic [4:0] pal_lookup(input logic [4:0] idx);
        pal_lookup = (idx[1:0] == 2'b00) ? 5'd0 : pal_mirror(idx);
    endfunction

endpackage

// File: rtl/nes_rgb_lut.sv
// Registered 6-bit NES colour to 24-bit RGB conversion; holds its output
// whenever no new colour is presented.
module nes_rgb_lut
    import ppu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [5:0]  color,
    output logic [23:0] rgb
);

    // Output colour register
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb <= 24'd0;
        end else if (en) begin
            rgb <= RGB_TABLE[color];
        end
    end

endmodule

// File: rtl/ppu_pixel_out.sv
// PPU pixel output: palette RAM, visible-dot qualification and a two-stage
// colour pipeline feeding a linear framebuffer address plus RGB.
module ppu_pixel_out
    import ppu_pkg::*;
#(
    parameter int VIS_LINES = DEF_VIS_LINES,
    parameter int VIS_DOTS  = DEF_VIS_DOTS
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  pal_index,
    input  logic [8:0]  xIdx,
    input  logic [8:0]  yIdx,
    input  logic        greyscale,
    input  logic        pal_wr,
    input  logic [13:0] pal_addr,
    input  logic [7:0]  pal_wdata,
    output logic [5:0]  pal_rdata,
    output logic        pix_valid,
    output logic [15:0] pix_addr,
    output logic [23:0] pix_rgb,
    output logic        frame_done
);

    localparam logic [15:0] LAST_ADDR = 16'((VIS_LINES - 1) * 256 + VIS_DOTS - 1);

    logic [5:0]  pal_ram [0:31];
    logic        clr_active;
    logic [4:0]  clr_idx;
    logic        pal_hit;
    logic [4:0]  pal_ent;
    logic        ram_we;
    logic [4:0]  ram_waddr;
    logic [5:0]  ram_wdata;
    logic        dot_vis;
    logic [15:0] dot_addr;
    dot_t        s0;
    pix_t        s1;
    logic [5:0]  lut_color;
    logic        armed;
    logic        unused_bits;

    assign unused_bits = ^{pal_addr[7:5], pal_wdata[7:6]};

    // Dot qualification and framebuffer address (column is xIdx-1)
    always_comb begin
        dot_vis  = (xIdx >= 9'd1) && (32'(xIdx) <= VIS_DOTS) &&
                   (32'(yIdx) < VIS_LINES) && !clr_active;
        dot_addr = ({7'd0, yIdx} << 8) + {7'd0, xIdx} - 16'd1;
    end

    // Palette write port: the post-reset clear sweep owns it until done
    always_comb begin
        pal_hit = (pal_addr[13:8] == PALETTE_BASE[13:8]);
        pal_ent = pal_mirror(pal_addr[4:0]);
        if (reset) begin
            ram_we    = 1'b0;
            ram_waddr = clr_idx;
            ram_wdata = 6'd0;
        end else if (clr_active) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = 6'd0;
        end else begin
            ram_we    = pal_wr && pal_hit;
            ram_waddr = pal_ent;
            ram_wdata = pal_wdata[5:0];
        end
    end

    // Clear sweep sequencer, one entry per cycle after reset releases
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_active <= 1'b1;
            clr_idx    <= 5'd0;
        end else if (clr_active) begin
            clr_idx <= clr_idx + 5'd1;
            if (clr_idx == 5'd31) begin
                clr_active <= 1'b0;
            end
        end
    end

    // Palette storage
    always_ff @(posedge clock) begin
        if (ram_we) begin
            pal_ram[ram_waddr] <= ram_wdata;
        end
    end

    // CPU-side palette readback; reads before a same-cycle write lands
    always_ff @(posedge clock) begin
        if (reset) begin
            pal_rdata <= 6'd0;
        end else if (pal_hit) begin
            pal_rdata <= pal_ram[pal_ent];
        end else begin
            pal_rdata <= 6'd0;
        end
    end

    // Input capture stage
    always_ff @(posedge clock) begin
        if (reset) begin
            s0 <= '0;
        end else begin
            s0.valid <= dot_vis;
            s0.addr  <= dot_addr;
            s0.grey  <= greyscale;
            s0.index <= pal_index;
        end
    end

    // Palette entry stage
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1.valid <= s0.valid;
            s1.addr  <= s0.addr;
            s1.grey  <= s0.grey;
            s1.color <= pal_ram[pal_lookup(s0.index)];
        end
    end

    assign lut_color = s1.grey ? (s1.color & 6'h30) : s1.color;

    nes_rgb_lut u_lut (
        .clock (clock),
        .reset (reset),
        .en    (s1.valid),
        .color (lut_color),
        .rgb   (pix_rgb)
    );

    // Output stage: address holds across non-visible dots
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_addr  <= 16'd0;
        end else begin
            pix_valid <= s1.valid;
            if (s1.valid) begin
                pix_addr <= s1.addr;
            end
        end
    end

    // A frame only completes if its first pixel was emitted since reset
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_done <= 1'b0;
            armed      <= 1'b0;
        end else begin
            frame_done <= pix_valid && (pix_addr == LAST_ADDR) && armed;
            if (pix_valid && (pix_addr == 16'd0)) begin
                armed <= 1'b1;
            end else if (pix_valid && (pix_addr == LAST_ADDR)) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_pixel_out.sv
// Directed bench for ppu_pixel_out: palette access, colour pipeline, visibility
// boundaries, reset abort and a full frame, checked through a pixel scoreboard.
module tb_ppu_pixel_out;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  pal_index = 5'd0;
    logic [8:0]  xIdx = 9'd0;
    logic [8:0]  yIdx = 9'd0;
    logic        greyscale = 1'b0;
    logic        pal_wr = 1'b0;
    logic [13:0] pal_addr = 14'd0;
    logic [7:0]  pal_wdata = 8'd0;
    logic [5:0]  pal_rdata;
    logic        pix_valid;
    logic [15:0] pix_addr;
    logic [23:0] pix_rgb;
    logic        frame_done;

    typedef struct packed {
        logic [15:0] addr;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pix_cnt = 0;
    int   done_cnt = 0;
    logic prev_last = 1'b0;

    ppu_pixel_out #(.VIS_LINES(240), .VIS_DOTS(256)) dut (
        .clock      (clock),
        .reset      (reset),
        .pal_index  (pal_index),
        .xIdx       (xIdx),
        .yIdx       (yIdx),
        .greyscale  (greyscale),
        .pal_wr     (pal_wr),
        .pal_addr   (pal_addr),
        .pal_wdata  (pal_wdata),
        .pal_rdata  (pal_rdata),
        .pix_valid  (pix_valid),
        .pix_addr   (pix_addr),
        .pix_rgb    (pix_rgb),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    // Pixel and frame_done monitor, sampled mid-cycle
    always @(negedge clock) begin
        exp_t e;
        if (pix_valid === 1'b1) begin
            pix_cnt++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL pixel_unexpected: got addr %h rgb %h, expected no pixel", pix_addr, pix_rgb);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (pix_addr === e.addr && pix_rgb === e.rgb) else begin
                    errors++;
                    $error("FAIL pixel: got addr %h rgb %h, expected addr %h rgb %h",
                           pix_addr, pix_rgb, e.addr, e.rgb);
                end
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            checks++;
            assert (prev_last) else begin
                errors++;
                $error("FAIL done_timing: got frame_done=1, expected it only after pixel efff");
            end
        end
        prev_last = (pix_valid === 1'b1) && (pix_addr === 16'hEFFF);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [23:0] r);
        exp_t e;
        e.addr = a;
        e.rgb  = r;
        sb.push_back(e);
    endtask

    task automatic dot(input int x, input int y, input logic [4:0] idx, input logic g);
        xIdx      = 9'(x);
        yIdx      = 9'(y);
        pal_index = idx;
        greyscale = g;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) dot(0, 0, 5'd0, 1'b0);
    endtask

    task automatic wr(input logic [13:0] a, input logic [7:0] d);
        pal_wr    = 1'b1;
        pal_addr  = a;
        pal_wdata = d;
        xIdx      = 9'd0;
        tick();
        pal_wr    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [13:0] a, input logic [5:0] expv);
        pal_addr = a;
        xIdx     = 9'd0;
        tick();
        chk(tag, 32'(pal_rdata), 32'(expv));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic chk_reset_state();
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_addr", 32'(pix_addr), 32'd0);
        chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("rst_pal_rdata", 32'(pal_rdata), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    initial begin
        do_reset();
        chk_reset_state();
        idle(34);

        // Palette access, mirroring and address decode
        wr(14'h3F10, 8'h21);
        rd("rd_mirror_3f00", 14'h3F00, 6'h21);
        rd("rd_mirror_3f10", 14'h3F10, 6'h21);
        rd("rd_outside", 14'h2F00, 6'h00);
        wr(14'h2F01, 8'h3F);
        rd("wr_outside_ignored", 14'h3F01, 6'h00);

        // Colour pipeline: plain, greyscale, backdrop
        wr(14'h3F05, 8'h16);
        push(16'h0000, 24'hF83800);
        dot(1, 0, 5'h05, 1'b0);
        wr(14'h3F06, 8'h16);
        push(16'h0001, 24'hBCBCBC);
        dot(2, 0, 5'h06, 1'b1);
        wr(14'h3F00, 8'h0F);
        push(16'h0002, 24'h000000);
        dot(3, 0, 5'h0C, 1'b0);

        // Visibility boundaries
        dot(0, 5, 5'h05, 1'b0);
        push(16'h05FF, 24'hF83800);
        dot(256, 5, 5'h05, 1'b0);
        dot(257, 5, 5'h05, 1'b0);
        dot(400, 5, 5'h05, 1'b0);
        push(16'hEF00, 24'hF83800);
        dot(1, 239, 5'h05, 1'b0);
        dot(1, 240, 5'h05, 1'b0);
        dot(1, 300, 5'h05, 1'b0);
        idle(4);

        // Lookup of dot(1,1) coincides with the write; dot(2,1) sees the new entry
        push(16'h0100, 24'hF83800);
        dot(1, 1, 5'h05, 1'b0);
        pal_wr    = 1'b1;
        pal_addr  = 14'h3F05;
        pal_wdata = 8'h21;
        push(16'h0101, 24'h3CBCFC);
        dot(2, 1, 5'h05, 1'b0);
        pal_wr    = 1'b0;
        idle(4);

        // Same-cycle write and read returns the old entry
        pal_wr    = 1'b1;
        pal_addr  = 14'h3F05;
        pal_wdata = 8'h16;
        xIdx      = 9'd0;
        tick();
        pal_wr    = 1'b0;
        chk("rd_during_wr_old", 32'(pal_rdata), 32'h21);
        rd("rd_after_wr_new", 14'h3F05, 6'h16);
        chk("done_none_directed", 32'(done_cnt), 32'd0);

        // Reset mid-frame at line 100, then the clear window
        for (int x = 1; x <= 20; x++) begin
            push(16'(100 * 256 + x - 1), 24'hF83800);
            dot(x, 100, 5'h05, 1'b0);
        end
        do_reset();
        chk_reset_state();
        for (int x = 1; x <= 32; x++) begin
            pal_wr    = (x == 5);
            pal_addr  = 14'h3F00;
            pal_wdata = 8'h2A;
            dot(x, 100, 5'h05, 1'b0);
        end
        pal_wr = 1'b0;
        push(16'h6420, 24'h7C7C7C);
        dot(33, 100, 5'h05, 1'b0);
        idle(4);
        rd("clear_wr_ignored", 14'h3F00, 6'h00);
        rd("clear_rd_zero", 14'h3F05, 6'h00);

        // Finish the aborted frame: its last pixel must not signal frame_done
        for (int y = 238; y <= 239; y++) begin
            for (int x = 0; x <= 257; x++) begin
                if (x >= 1 && x <= 256) push(16'(y * 256 + x - 1), 24'h7C7C7C);
                dot(x, y, 5'h05, 1'b0);
            end
        end
        idle(4);
        chk("no_done_after_abort", 32'(done_cnt), 32'd0);

        // Full frame; dots past column 257 are invisible and covered above
        wr(14'h3F00, 8'h21);
        wr(14'h3F01, 8'h2A);
        idle(4);
        pix_cnt  = 0;
        done_cnt = 0;
        for (int y = 0; y <= 240; y++) begin
            for (int x = 0; x <= 257; x++) begin
                if (x >= 1 && x <= 256 && y < 240)
                    push(16'(y * 256 + x - 1), (x % 2 == 1) ? 24'h58D854 : 24'h3CBCFC);
                dot(x, y, (x % 2 == 1) ? 5'h01 : 5'h1C, 1'b0);
            end
        end
        idle(4);
        chk("frame_pixel_count", 32'(pix_cnt), 32'd61440);
        chk("frame_done_count", 32'(done_cnt), 32'd1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
